// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared entry type, counter sizing and PC alignment helper for the fetch stage.
package fetch_unit_pkg;
  localparam int FU_ADDR_W = 16;
  localparam int FU_INSTR_W = 16;
  typedef struct packed {
    logic [FU_ADDR_W-1:0]  pc;
    logic [FU_INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic logic pc_aligned(input logic [31:0] addr, input int inc);
    return (addr & ((32'd1 << $clog2(inc)) - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with registered head; flush has priority over push.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            din,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic [W-1:0]            head,
  output logic                    empty,
  output logic                    full
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    count = cnt_q;
    head = mem_q[rd_q];
    do_push = push && !flush;
    do_pop = pop && !empty && !flush;
    rd_d = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
    wr_d = flush ? '0 : do_push ? nxt(wr_q) : wr_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing credit-limited fetches, buffering in-order responses for decode,
// with redirect flush of buffered and in-flight fetches and a sticky error flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = FU_ADDR_W,
  parameter int                INSTR_W  = FU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 2,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               err
);
  localparam int CW = cnt_w(DEPTH);
  fetch_entry_t push_e, head_e;
  logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_cnt;
  logic err_q, err_d, started_q, fifo_empty, fifo_full;
  logic credit, req_fire, rsp_ok, push, pop, flush, misalign;
  // Outstanding includes responses still to be dropped, so stale fetches keep holding FIFO slots.
  assign credit = 32'(fifo_cnt) + 32'(out_q) < 32'(DEPTH);
  always_comb begin
    misalign = redirect_valid && !pc_aligned(32'(redirect_pc), PC_INC);
    mem_req_valid = started_q && !err_q && !redirect_valid && credit;
    mem_req_addr = pc_q;
    instr_valid = !fifo_empty && !redirect_valid && !err_q;
    instr = head_e.instr;
    instr_pc = head_e.pc;
    err = err_q;
    req_fire = mem_req_valid && mem_req_ready;
    rsp_ok = mem_rsp_valid && out_q != '0;
    pop = instr_valid && instr_ready;
    push = rsp_ok && drop_q == '0 && !redirect_valid && !err_q && (!fifo_full || pop);
    flush = redirect_valid || err_q;
    push_e = '{pc: rsp_pc_q, instr: mem_rsp_data};
    out_d = out_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d = redirect_valid ? out_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
    pc_d = redirect_valid ? redirect_pc : req_fire ? pc_q + ADDR_W'(PC_INC) : pc_q;
    rsp_pc_d = redirect_valid ? redirect_pc : push ? rsp_pc_q + ADDR_W'(PC_INC) : rsp_pc_q;
    err_d = err_q || misalign || (mem_rsp_valid && out_q == '0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      err_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      err_q <= err_d;
      started_q <= 1'b1;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(push_e),
    .count(fifo_cnt),
    .head(head_e),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with an in-order variable-latency memory model (instr = addr + 0x1000).
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic redirect_valid, mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic instr_valid, instr_ready, err;
  logic [15:0] redirect_pc, mem_req_addr, mem_rsp_data, instr, instr_pc;
  int n_chk = 0, n_fail = 0, lat = 1, cyc_n = 0;
  bit inject = 1'b0;
  typedef struct {
    logic [15:0] a;
    int due;
  } pend_t;
  pend_t pend[$];
  logic [15:0] req_q[$], del_pc[$], del_in[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      cyc_n = 0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data <= '0;
    end else begin
      if (mem_req_valid && mem_req_ready) pend.push_back('{mem_req_addr, cyc_n + lat - 1});
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data <= pend[0].a + 16'h1000;
        void'(pend.pop_front());
      end else if (inject) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data <= 16'hDEAD;
      end else mem_rsp_valid <= 1'b0;
      cyc_n++;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (mem_req_valid && mem_req_ready) req_q.push_back(mem_req_addr);
      if (instr_valid && instr_ready) begin
        del_pc.push_back(instr_pc);
        del_in.push_back(instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b0;
    lat = l;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b0;
    instr_ready = 1'b0;
    inject = 1'b0;
    req_q.delete();
    del_pc.delete();
    del_in.delete();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input string tag);
    for (int i = 0; i < 50 && req_q.size() < n; i++) cyc();
    chk(tag, req_q.size() >= n, 1);
  endtask

  initial begin
    int stale;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b0;
    instr_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_req_addr, 16'h0000);

    do_reset(1);
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    #1 chk("release_req_valid", mem_req_valid, 0);
    cyc();
    chk("first_req_valid", mem_req_valid, 1);
    chk("first_req_addr", mem_req_addr, 16'h0000);
    repeat (12) cyc();
    chk("seq_req_cnt", req_q.size() >= 3, 1);
    chk("seq_req0", req_q[0], 16'h0000);
    chk("seq_req1", req_q[1], 16'h0002);
    chk("seq_req2", req_q[2], 16'h0004);
    chk("seq_del_cnt", del_pc.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_pc%0d", i), del_pc[i], 32'(2 * i));
      chk($sformatf("seq_instr%0d", i), del_in[i], 32'(2 * i + 16'h1000));
    end

    do_reset(1);
    mem_req_ready = 1'b1;
    repeat (7) cyc();
    chk("stall_req_cnt", req_q.size(), 2);
    chk("stall_req_valid", mem_req_valid, 0);
    chk("stall_instr_valid", instr_valid, 1);
    chk("stall_head_pc", instr_pc, 16'h0000);
    chk("stall_head_instr", instr, 16'h1000);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    repeat (5) cyc();
    chk("stall_pop_cnt", del_pc.size(), 1);
    chk("stall_pop_pc", del_pc[0], 16'h0000);
    chk("stall_req_after_pop", req_q.size(), 3);
    chk("stall_new_addr", req_q[2], 16'h0004);
    chk("stall_new_head", instr_pc, 16'h0002);
    chk("stall_req_valid2", mem_req_valid, 0);

    do_reset(3);
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    wait_reqs(2, "lat3_two_out");
    chk("lat3_nothing_yet", del_pc.size(), 0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    #1 chk("lat3_redir_no_req", mem_req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    repeat (25) cyc();
    chk("lat3_first_pc", del_pc[0], 16'h0100);
    chk("lat3_first_instr", del_in[0], 16'h1100);
    chk("lat3_second_pc", del_pc[1], 16'h0102);
    chk("lat3_resume_addr", req_q[2], 16'h0100);
    stale = 0;
    foreach (del_pc[i]) if (del_pc[i] < 16'h0100) stale++;
    chk("lat3_no_stale", stale, 0);
    chk("lat3_err", err, 0);

    do_reset(1);
    mem_req_ready = 1'b1;
    repeat (6) cyc();
    chk("coll_full_head", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("coll_req_valid", mem_req_valid, 1);
    chk("coll_req_addr", mem_req_addr, 16'h0004);
    cyc();
    chk("coll_head_pc", instr_pc, 16'h0002);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    instr_ready = 1'b1;
    #1;
    chk("coll_no_pop", instr_valid, 0);
    chk("coll_no_req", mem_req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("coll_empty", instr_valid, 0);
    chk("coll_resume", mem_req_valid, 1);
    chk("coll_target", mem_req_addr, 16'h0200);
    repeat (6) cyc();
    chk("coll_del0", del_pc[0], 16'h0000);
    chk("coll_del1", del_pc[1], 16'h0200);
    chk("coll_instr1", del_in[1], 16'h1200);

    do_reset(1);
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (4) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0101;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("mis_err", err, 1);
    chk("mis_req_valid", mem_req_valid, 0);
    chk("mis_instr_valid", instr_valid, 0);
    stale = req_q.size();
    repeat (6) cyc();
    chk("mis_err_sticky", err, 1);
    chk("mis_req_valid_later", mem_req_valid, 0);
    chk("mis_instr_valid_later", instr_valid, 0);
    chk("mis_no_new_reqs", req_q.size(), stale);

    do_reset(1);
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    repeat (10) cyc();
    chk("wrap_req0", req_q[0], 16'hFFFE);
    chk("wrap_req1", req_q[1], 16'h0000);
    chk("wrap_pc0", del_pc[0], 16'hFFFE);
    chk("wrap_instr0", del_in[0], 16'h0FFE);
    chk("wrap_pc1", del_pc[1], 16'h0000);
    chk("wrap_instr1", del_in[1], 16'h1000);
    chk("wrap_err", err, 0);

    do_reset(1);
    mem_req_ready = 1'b1;
    repeat (6) cyc();
    chk("mid_full_valid", instr_valid, 1);
    chk("mid_pc_adv", mem_req_addr, 16'h0004);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_instr_valid", instr_valid, 0);
    chk("mid_async_addr", mem_req_addr, 16'h0000);
    chk("mid_async_req_valid", mem_req_valid, 0);
    cyc();
    rst = 1'b1;
    mem_req_ready = 1'b0;
    repeat (2) cyc();
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    cyc();
    chk("spur_err", err, 1);
    chk("spur_instr_valid", instr_valid, 0);
    chk("spur_req_valid", mem_req_valid, 0);
    #2 rst = 1'b0;
    #1;
    chk("spur_rst_err", err, 0);
    chk("spur_rst_addr", mem_req_addr, 16'h0000);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    chk("spur_resume", mem_req_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch stage that replaces the fixed pc+2 / always-enabled fetch.
- Owns the PC and issues requests to a variable-latency instruction memory over a valid/ready interface.
- Buffers responses in a small FIFO and presents instructions with their PC to decode over a valid/ready handshake.
- Supports redirect (branch/jump target) with flush of buffered and in-flight fetches, and raises a sticky error on misaligned targets or protocol violations.

Parameters:
- ADDR_W, 16, PC and memory address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 2, PC increment per fetch; must be a power of two; also the alignment requirement.
- DEPTH, 2, instruction FIFO depth; also the maximum number of requests outstanding; must be at least 1.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  fetch address (current PC).
- mem_rsp_valid  in  1  response data valid; responses arrive in order, one per cycle max.
- mem_rsp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  FIFO head valid to decode.
- instr_ready  in  1  decode consumes the head.
- instr  out  INSTR_W  instruction at FIFO head.
- instr_pc  out  ADDR_W  PC of the head instruction.
- err  out  1  sticky error.

Behaviour:
- Reset (rst low, asynchronous):
  - pc = rsp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0; err = 0.
  - mem_req_valid, instr_valid and err read 0 until the first edge after reset release.
- Request issue:
  - mem_req_valid = !err && !redirect_valid && (fifo_count + outstanding < DEPTH).
  - mem_req_addr = pc.
  - On a handshake (valid && ready): pc <= pc + PC_INC, modulo 2^ADDR_W, wrapping silently. outstanding increments.
  - mem_req_addr is held stable while valid and not ready.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {rsp_pc, mem_rsp_data} into the FIFO and advance rsp_pc by PC_INC (wrapping).
  - The credit rule guarantees a push never finds the FIFO full.
- Output:
  - instr_valid = FIFO not empty && !redirect_valid.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are legal at any occupancy.
  - Zero-bubble: a response accepted at edge N is visible at the head after edge N.
  - Minimum latency from request handshake to instr_valid is memory latency plus 1 cycle.
- Redirect (has priority over everything else):
  - No request is issued and no pop occurs in the redirect cycle.
  - At the next edge: pc = rsp_pc = redirect_pc and the FIFO is flushed.
  - drop_cnt = outstanding minus 1 if a response arrives in the same cycle (that response is itself discarded).
  - Back-to-back redirects: the last one wins and drop_cnt accumulates correctly.
  - Requests resume the cycle after the redirect if credit is available. Credit counts drop_cnt inside outstanding, so stale responses still hold slots.
- Errors:
  - Misaligned redirect (redirect_pc mod PC_INC != 0): err = 1 at the next edge, FIFO flushed, no further requests.
  - mem_rsp_valid while outstanding == 0: err = 1 and the response is ignored.
  - err stays set until reset; in-flight responses are still counted and discarded.
- Reset mid-operation: all state clears immediately. The memory model is expected to drop in-flight responses on the same reset.

Decomposition:
- Shared package holds:
  - the fetch entry struct {pc, instr};
  - the alignment-check function (log2 of PC_INC);
  - the count width constant $clog2(DEPTH+1).
- One sub-module: fetch_fifo, a parametrised synchronous FIFO (DEPTH, entry width) with push, pop, flush, count, head, empty and full; flush has priority over push.
- PC update, credit logic and drop counter stay in fetch_unit.
- The PC adder stays inline as a plain "+".

Test Plan:
- Reset release, 1-cycle memory, instr_ready = 1 -> addresses 0x0000, 0x0002, 0x0004 are requested on consecutive cycles; instr_pc follows 0x0000, 0x0002, ... with instr matching memory; steady state delivers one instruction per cycle.
- instr_ready = 0 with DEPTH = 2 -> exactly 2 requests issue, then mem_req_valid = 0; raise ready -> head pc 0x0000 pops and exactly one new request issues per pop.
- 3-cycle memory latency, redirect to 0x0100 with 2 outstanding -> both stale responses are dropped, next instr_pc = 0x0100, and no stale instruction ever reaches decode.
- Redirect in the same cycle a response arrives and decode pops -> no pop occurs, the response is discarded, FIFO is empty next cycle, and fetch resumes at the target.
- Redirect to 0x0101 -> err = 1 next cycle, mem_req_valid stays 0 and instr_valid = 0 until reset; with pc at 0xFFFE the next request address wraps to 0x0000.
- Spurious mem_rsp_valid with nothing outstanding -> err = 1; asserting rst mid-stream clears err, the FIFO and the PC to RESET_PC asynchronously.
